booth_mul8: RTL and testbench

Sequential signed multiplier for the 8-bit ALU using radix-2 Booth's algorithm. It takes two signed WIDTH-bit operands and produces a 2·WIDTH-bit signed product after a fixed number of cycles. It sits beside the combinational add/sub path on the ALU operand bus. Its A, Q, Q-1, M and counter state are held in registers built from the team's gate-level D flip-flop cell.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/reg_n.sv | 39 +++
 rtl/booth_mul8.sv | 94 +++++++++
 tb/tb_booth_mul8.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: shared definitions for the ALU datapath blocks.
// Rev 1.0
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of the pair {Q[0], Q-1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_n.sv
`default_nettype none
// reg_n: N-bit register from per-bit dff cells, synchronous reset, load enable.
// Rev 1.0
module dff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

module reg_n #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] d_mux;

  // Enable is a recirculating mux in front of each cell.
  assign d_mux = en ? d : q;

  for (genvar i = 0; i < N; i++) begin : g_bit
    dff u_dff (
      .clk  (clk),
      .reset(reset),
      .d    (d_mux[i]),
      .q    (q[i])
    );
  end
endmodule
`default_nettype wire

// File: rtl/booth_mul8.sv
`default_nettype none
// booth_mul8: sequential radix-2 Booth signed multiplier, 2*WIDTH-bit product.
// Rev 1.0
module booth_mul8
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]     a_q, a_d, m_q, m_d, addsub;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         state_bits;
  state_e             state, state_d;
  logic               m_en, prod_en, sub;
  logic [2*WIDTH-1:0] prod_d;
  booth_op_e          op;

  assign state = state_e'(state_bits);
  assign op    = booth_decode(q_q[0], qm1_q);
  assign sub   = (op == OP_SUB);
  assign addsub = a_q + (m_q ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};

  // Product is captured from the final shift result so it lands with DONE.
  assign prod_d = {a_q, q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    m_en    = 1'b0;
    prod_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_d     = '0;
          m_d     = {x[WIDTH-1], x};
          m_en    = 1'b1;
          q_d     = y;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        busy = 1'b1;
        if (op != OP_NOP) a_d = addsub;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        {a_d, q_d, qm1_d} = {a_q[WIDTH], a_q, q_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          prod_en = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  reg_n #(.N(WIDTH+1)) u_a   (.clk(clk), .reset(reset), .en(1'b1),    .d(a_d),     .q(a_q));
  reg_n #(.N(WIDTH+1)) u_m   (.clk(clk), .reset(reset), .en(m_en),    .d(m_d),     .q(m_q));
  reg_n #(.N(WIDTH))   u_q   (.clk(clk), .reset(reset), .en(1'b1),    .d(q_d),     .q(q_q));
  reg_n #(.N(1))       u_qm1 (.clk(clk), .reset(reset), .en(1'b1),    .d(qm1_d),   .q(qm1_q));
  reg_n #(.N(CW))      u_cnt (.clk(clk), .reset(reset), .en(1'b1),    .d(cnt_d),   .q(cnt_q));
  reg_n #(.N(2))       u_st  (.clk(clk), .reset(reset), .en(1'b1),    .d(state_d), .q(state_bits));
  reg_n #(.N(2*WIDTH)) u_prd (.clk(clk), .reset(reset), .en(prod_en), .d(prod_d),  .q(product));

endmodule
`default_nettype wire

// File: tb/tb_booth_mul8.sv
`default_nettype none
// tb_booth_mul8: randomized and directed checks of booth_mul8 against a cycle-level behavioural model.
module tb_booth_mul8;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b1;
  logic [7:0]  x = 8'h00;
  logic [7:0]  y = 8'h00;
  logic        busy, done;
  logic [15:0] product;

  booth_mul8 #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase counts edges since the accepting edge, -1 when idle.
  int          cyc = 0;
  int          phase = -1;
  logic [15:0] eprod = 16'h0000;
  logic [15:0] pend = 16'h0000;
  bit          model_on = 1'b0;
  int          acc_q[$];

  always @(posedge clk) begin
    int p;
    cyc++;
    if (reset) begin
      phase    = -1;
      eprod    = 16'h0000;
      model_on = 1'b1;
    end else if (phase < 0) begin
      if (start) begin
        phase = 0;
        p     = int'($signed(x)) * int'($signed(y));
        pend  = p[15:0];
        acc_q.push_back(cyc);
      end
    end else begin
      phase++;
      if (phase == 16) eprod = pend;
      if (phase == 17) phase = -1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", {15'd0, busy}, {15'd0, (phase >= 0 && phase < 16)});
      chk("done", {15'd0, done}, {15'd0, (phase == 16)});
      chk("product", product, eprod);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) chk("idle_timeout", 16'd1, 16'd0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] lit, input string nm);
    int n;
    wait_idle();
    x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 16'(n), 16'd17);
    chk({nm, "_product"}, product, lit);
    chk({nm, "_busy_on_done"}, {15'd0, busy}, 16'd0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    int n;
    // Reset held with start high: nothing accepted.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_product", product, 16'h0000);
    chk("rst_no_accept", 16'(acc_q.size()), 16'd0);
    @(negedge clk);

    run_op(8'h07, 8'h03, 16'h0015, "mul_7x3");
    run_op(8'hFB, 8'h06, 16'hFFE2, "mul_m5x6");
    run_op(8'h06, 8'hFB, 16'hFFE2, "mul_6xm5");
    run_op(8'h00, 8'h80, 16'h0000, "mul_0xm128");
    run_op(8'h80, 8'h80, 16'h4000, "mul_m128xm128");
    run_op(8'h80, 8'h7F, 16'hC080, "mul_m128x127");
    run_op(8'h7F, 8'h7F, 16'h3F01, "mul_127x127");

    // Start held high, operands scrambled after accept; back-to-back at E18.
    wait_idle();
    x = 8'h07; y = 8'h03; start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin
      x = 8'($urandom); y = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk("held_product", product, 16'h0015);
    repeat (3) @(negedge clk);
    start = 1'b0;
    if (acc_q.size() >= 2)
      chk("b2b_accept_gap", 16'(acc_q[$] - acc_q[$-1]), 16'd18);
    else
      chk("b2b_accept_count", 16'(acc_q.size()), 16'd2);

    // Reset mid-operation at the 5th edge after accept.
    wait_idle();
    x = 8'h12; y = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_done", {15'd0, done}, 16'd0);
    chk("midrst_product", product, 16'h0000);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("midrst_no_done", 16'(n), 16'd0);
    run_op(8'h07, 8'h03, 16'h0015, "after_rst");

    // Random traffic with occasional resets; the compare process checks each cycle.
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 3) == 0);
      x     = 8'($urandom);
      y     = 8'($urandom);
      reset = ($urandom_range(0, 80) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
